// File: rtl/board_cell_renderer.sv
// Game-layer pixel renderer: maps the beam onto the board, fetches cell state and colours each pixel.
// Optional feature: define CURSOR_BLINK_EN to blink the cursor outline every 16 frames.
module board_cell_renderer #(
    parameter int unsigned VGA_WIDTH  = 12,
    parameter int unsigned HMAX       = 800,
    parameter int unsigned VMAX       = 525,
    parameter int unsigned BOARD_X    = 80,
    parameter int unsigned BOARD_Y    = 0,
    parameter int unsigned CELL_SHIFT = 5,
    parameter int unsigned BOARD_N    = 15,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic                 clk_vga,
    input  logic                 reset_n,
    input  logic [VGA_WIDTH-1:0] hdata_i,
    input  logic [VGA_WIDTH-1:0] vdata_i,
    input  logic [3:0]           cursor_row_i,
    input  logic [3:0]           cursor_col_i,
    output logic [ADDR_W-1:0]    cell_addr_o,
    input  logic [7:0]           cell_data_i,
    output logic [7:0]           gen_red,
    output logic [7:0]           gen_green,
    output logic [7:0]           gen_blue,
    output logic                 use_gen
);

    localparam int unsigned EXT_W = VGA_WIDTH + 1;
    localparam int unsigned SIZE  = 1 << CELL_SHIFT;
    localparam int unsigned SPAN  = BOARD_N << CELL_SHIFT;
    localparam int unsigned IDX_W = 4;

    // S0: lookahead target, three pixels ahead of the beam, wrapped to the frame
    logic [EXT_W-1:0]     la_h_c, la_v_c;
    logic [VGA_WIDTH-1:0] t_h, t_v;
    logic                 s0_valid;

    always_comb begin
        la_h_c = EXT_W'(hdata_i) + EXT_W'(3);
        la_v_c = EXT_W'(vdata_i);
        if (la_h_c >= EXT_W'(HMAX)) begin
            la_h_c = la_h_c - EXT_W'(HMAX);
            la_v_c = la_v_c + EXT_W'(1);
        end
        if (la_v_c >= EXT_W'(VMAX)) la_v_c = '0;
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            t_h      <= '0;
            t_v      <= '0;
            s0_valid <= 1'b0;
        end else begin
            t_h      <= VGA_WIDTH'(la_h_c);
            t_v      <= VGA_WIDTH'(la_v_c);
            s0_valid <= 1'b1;
        end
    end

    // S1: cell lookup; offsets below the board origin wrap high and fail the span test
    logic [EXT_W-1:0]      dx_c, dy_c;
    logic                  in_board_c;
    logic [IDX_W-1:0]      col_c, row_c;
    logic                  s1_valid, s1_in_board, s1_cursor;
    logic [CELL_SHIFT-1:0] s1_x, s1_y;

    always_comb begin
        dx_c       = EXT_W'(t_h) - EXT_W'(BOARD_X);
        dy_c       = EXT_W'(t_v) - EXT_W'(BOARD_Y);
        in_board_c = (dx_c < EXT_W'(SPAN)) && (dy_c < EXT_W'(SPAN));
        col_c      = IDX_W'(dx_c >> CELL_SHIFT);
        row_c      = IDX_W'(dy_c >> CELL_SHIFT);
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            cell_addr_o <= '0;
            s1_valid    <= 1'b0;
            s1_in_board <= 1'b0;
            s1_cursor   <= 1'b0;
            s1_x        <= '0;
            s1_y        <= '0;
        end else begin
            if (in_board_c)
                cell_addr_o <= ADDR_W'(row_c) * ADDR_W'(BOARD_N) + ADDR_W'(col_c);
            s1_valid    <= s0_valid;
            s1_in_board <= in_board_c;
            s1_cursor   <= in_board_c && (row_c == cursor_row_i) && (col_c == cursor_col_i);
            s1_x        <= dx_c[CELL_SHIFT-1:0];
            s1_y        <= dy_c[CELL_SHIFT-1:0];
        end
    end

    logic cursor_vis_c;
`ifdef CURSOR_BLINK_EN
    // Frame counter steps once per frame, when the lookahead target reaches the origin
    logic [4:0] frame_cnt;

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n)
            frame_cnt <= '0;
        else if (s0_valid && (t_h == '0) && (t_v == '0))
            frame_cnt <= frame_cnt + 5'd1;
    end

    assign cursor_vis_c = ~frame_cnt[4];
`else
    assign cursor_vis_c = 1'b1;
`endif

    // S2: colour the pixel from the cell state, first matching rule wins
    logic [2:0]  owner_c;
    logic [1:0]  kind_c;
    logic        fog_c, edge_c, centre_c, show_c;
    logic [23:0] palette_c, rgb_c;
    logic        unused_c;

    assign unused_c = ^cell_data_i[1:0];

    always_comb begin
        owner_c  = cell_data_i[7:5];
        kind_c   = cell_data_i[4:3];
        fog_c    = cell_data_i[2];
        show_c   = s1_valid && s1_in_board;
        edge_c   = (s1_x < CELL_SHIFT'(2)) || (s1_x >= CELL_SHIFT'(SIZE - 2)) ||
                   (s1_y < CELL_SHIFT'(2)) || (s1_y >= CELL_SHIFT'(SIZE - 2));
        centre_c = (s1_x >= CELL_SHIFT'(SIZE / 4)) && (s1_x < CELL_SHIFT'(3 * SIZE / 4)) &&
                   (s1_y >= CELL_SHIFT'(SIZE / 4)) && (s1_y < CELL_SHIFT'(3 * SIZE / 4));
        case (owner_c)
            3'd0:    palette_c = 24'hC0C0C0;
            3'd1:    palette_c = 24'hFF0000;
            3'd2:    palette_c = 24'h0000FF;
            3'd3:    palette_c = 24'h00C000;
            3'd4:    palette_c = 24'h800080;
            3'd5:    palette_c = 24'hFF8000;
            3'd6:    palette_c = 24'h008080;
            default: palette_c = 24'h800000;
        endcase
        if (!show_c)                             rgb_c = 24'h000000;
        else if (cursor_vis_c && s1_cursor && edge_c) rgb_c = 24'hFFFFFF;
        else if ((s1_x == '0) || (s1_y == '0))  rgb_c = 24'h000000;
        else if (fog_c)                          rgb_c = 24'h404040;
        else if (kind_c == 2'd3)                 rgb_c = 24'h808080;
        else if (centre_c && (kind_c == 2'd2))   rgb_c = 24'hFFFFFF;
        else if (centre_c && (kind_c == 2'd1))
            rgb_c = {1'b0, palette_c[23:17], 1'b0, palette_c[15:9], 1'b0, palette_c[7:1]};
        else                                     rgb_c = palette_c;
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            gen_red   <= '0;
            gen_green <= '0;
            gen_blue  <= '0;
            use_gen   <= 1'b0;
        end else begin
            gen_red   <= rgb_c[23:16];
            gen_green <= rgb_c[15:8];
            gen_blue  <= rgb_c[7:0];
            use_gen   <= show_c;
        end
    end

endmodule
